count_adjacent_mines: RTL and testbench

- Reads the mine board after mine placement completes and computes, for every cell, the number of mines in its 8 neighbours.
- Writes each 0..8 count into the adjacency-count board.
- Sits between the mine-placement stage and the game/display logic. Uses the same start/ack handshake and one-hot state indicators as the other board-setup blocks.

---
 rtl/count_adjacent_mines_pkg.sv | 26 ++
 rtl/count_adjacent_mines_if.sv | 40 ++++
 rtl/count_adjacent_mines_neighbor_addr.sv | 67 ++++++
 rtl/count_adjacent_mines.sv | 135 +++++++++++++
 tb/tb_count_adjacent_mines.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/count_adjacent_mines_pkg.sv
// count_adjacent_mines_pkg
// Shared definitions for the board-setup blocks: default board size, the
// one-hot state encoding used by every setup stage, the neighbour-count
// width and the neighbour index constants that walk the 3x3 window.
// No ports; imported with count_adjacent_mines_pkg::*.
package count_adjacent_mines_pkg;

    localparam int DEFAULT_BOARD_WIDTH  = 8;
    localparam int DEFAULT_BOARD_HEIGHT = 8;

    // Widest possible count is 8, so four bits always suffice.
    localparam int COUNT_W = 4;

    // The 3x3 window is walked row-major: k = 3*row + col, centre is k = 4.
    localparam logic [3:0] K_FIRST  = 4'd0;
    localparam logic [3:0] K_CENTRE = 4'd4;
    localparam logic [3:0] K_LAST   = 4'd8;

    typedef enum logic [3:0] {
        ST_INIT  = 4'b0001,
        ST_SCAN  = 4'b0010,
        ST_WRITE = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

endpackage

// File: rtl/count_adjacent_mines_if.sv
// count_adjacent_mines_if
// Bundles the start/ack handshake, the mine-board read port, the
// count-board write port and the one-hot state indicators.
//   master : the adjacency counter (drives addresses, writes, indicators)
//   slave  : the surrounding game logic and board memories
// Parameters BOARD_WIDTH/BOARD_HEIGHT size the coordinate fields.
interface count_adjacent_mines_if
    import count_adjacent_mines_pkg::*;
#(
    parameter int BOARD_WIDTH  = DEFAULT_BOARD_WIDTH,
    parameter int BOARD_HEIGHT = DEFAULT_BOARD_HEIGHT
);
    localparam int XW = $clog2(BOARD_WIDTH);
    localparam int YW = $clog2(BOARD_HEIGHT);

    logic               start;
    logic               ack;
    logic [XW-1:0]      rdX;
    logic [YW-1:0]      rdY;
    logic               mineBoardReadValue;
    logic [XW-1:0]      wrX;
    logic [YW-1:0]      wrY;
    logic [COUNT_W-1:0] countOut;
    logic               writeEn;
    logic               init;
    logic               scan;
    logic               write;
    logic               done;

    modport master (
        input  start, ack, mineBoardReadValue,
        output rdX, rdY, wrX, wrY, countOut, writeEn, init, scan, write, done
    );

    modport slave (
        output start, ack, mineBoardReadValue,
        input  rdX, rdY, wrX, wrY, countOut, writeEn, init, scan, write, done
    );

endinterface

// File: rtl/count_adjacent_mines_neighbor_addr.sv
// neighbor_addr
// Purely combinational: maps a centre cell and a window index k (0..8)
// to the neighbour coordinate and whether it lies on the board.
//   cx_i, cy_i : centre cell
//   k_i        : window index, dx = k%3-1, dy = k/3-1
//   nx_o, ny_o : neighbour coordinate (meaningful only when valid_o)
//   valid_o    : neighbour is on the board and is not the centre itself
module neighbor_addr
    import count_adjacent_mines_pkg::*;
#(
    parameter  int BOARD_WIDTH  = DEFAULT_BOARD_WIDTH,
    parameter  int BOARD_HEIGHT = DEFAULT_BOARD_HEIGHT,
    localparam int XW           = $clog2(BOARD_WIDTH),
    localparam int YW           = $clog2(BOARD_HEIGHT)
) (
    input  logic [XW-1:0] cx_i,
    input  logic [YW-1:0] cy_i,
    input  logic [3:0]    k_i,
    output logic [XW-1:0] nx_o,
    output logic [YW-1:0] ny_o,
    output logic          valid_o
);

    logic [1:0]  colSel;
    logic [1:0]  rowSel;
    logic [XW:0] nxWide;
    logic [YW:0] nyWide;
    logic        xInRange;
    logic        yInRange;

    // Split k into column/row selectors without a divider. Any k above 8
    // falls onto the centre so it can never be reported as valid.
    always_comb begin
        colSel = 2'd1;
        rowSel = 2'd1;
        case (k_i)
            4'd0: begin colSel = 2'd0; rowSel = 2'd0; end
            4'd1: begin colSel = 2'd1; rowSel = 2'd0; end
            4'd2: begin colSel = 2'd2; rowSel = 2'd0; end
            4'd3: begin colSel = 2'd0; rowSel = 2'd1; end
            4'd5: begin colSel = 2'd2; rowSel = 2'd1; end
            4'd6: begin colSel = 2'd0; rowSel = 2'd2; end
            4'd7: begin colSel = 2'd1; rowSel = 2'd2; end
            4'd8: begin colSel = 2'd2; rowSel = 2'd2; end
            default: begin colSel = 2'd1; rowSel = 2'd1; end
        endcase
    end

    // Offsets are applied one bit wider than the coordinate, so stepping
    // left of column 0 lands far above the board and stepping right of the
    // last column is caught by the same upper-bound compare.
    always_comb begin
        nxWide = {1'b0, cx_i};
        nyWide = {1'b0, cy_i};
        if (colSel == 2'd0) nxWide = {1'b0, cx_i} - (XW+1)'(1);
        if (colSel == 2'd2) nxWide = {1'b0, cx_i} + (XW+1)'(1);
        if (rowSel == 2'd0) nyWide = {1'b0, cy_i} - (YW+1)'(1);
        if (rowSel == 2'd2) nyWide = {1'b0, cy_i} + (YW+1)'(1);
    end

    assign xInRange = (nxWide < (XW+1)'(BOARD_WIDTH));
    assign yInRange = (nyWide < (YW+1)'(BOARD_HEIGHT));
    assign valid_o  = xInRange && yInRange && (k_i != K_CENTRE) && (k_i <= K_LAST);
    assign nx_o     = nxWide[XW-1:0];
    assign ny_o     = nyWide[YW-1:0];

endmodule

// File: rtl/count_adjacent_mines.sv
// count_adjacent_mines
// After mine placement, visits every cell in row-major order, spends nine
// cycles reading its 3x3 window from the mine board and one cycle writing
// the neighbour-mine count (0..8) into the count board.
//   clk, reset : clock and asynchronous active-high reset
//   boardIf    : master side of count_adjacent_mines_if (start/ack,
//                mine-board read port, count-board write port,
//                one-hot init/scan/write/done indicators)
module count_adjacent_mines
    import count_adjacent_mines_pkg::*;
#(
    parameter int BOARD_WIDTH  = DEFAULT_BOARD_WIDTH,
    parameter int BOARD_HEIGHT = DEFAULT_BOARD_HEIGHT
) (
    input  logic                   clk,
    input  logic                   reset,
    count_adjacent_mines_if.master boardIf
);

    localparam int XW = $clog2(BOARD_WIDTH);
    localparam int YW = $clog2(BOARD_HEIGHT);

    state_e             stateQ, stateD;
    logic [XW-1:0]      cxQ, cxD;
    logic [YW-1:0]      cyQ, cyD;
    logic [3:0]         kQ, kD;
    logic [COUNT_W-1:0] accQ, accD;

    logic [XW-1:0]      nbX;
    logic [YW-1:0]      nbY;
    logic               nbValid;
    logic               lastCol;
    logic               lastCell;

    neighbor_addr #(
        .BOARD_WIDTH  (BOARD_WIDTH),
        .BOARD_HEIGHT (BOARD_HEIGHT)
    ) uNeighborAddr (
        .cx_i    (cxQ),
        .cy_i    (cyQ),
        .k_i     (kQ),
        .nx_o    (nbX),
        .ny_o    (nbY),
        .valid_o (nbValid)
    );

    assign lastCol  = (cxQ == XW'(BOARD_WIDTH - 1));
    assign lastCell = lastCol && (cyQ == YW'(BOARD_HEIGHT - 1));

    // State and datapath registers; reset returns to an idle INIT with
    // every counter cleared so a half-finished scan leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= ST_INIT;
            cxQ    <= '0;
            cyQ    <= '0;
            kQ     <= K_FIRST;
            accQ   <= '0;
        end else begin
            stateQ <= stateD;
            cxQ    <= cxD;
            cyQ    <= cyD;
            kQ     <= kD;
            accQ   <= accD;
        end
    end

    // Next-state and outputs. Every window slot costs exactly one SCAN
    // cycle, including the centre and off-board slots, so each cell takes
    // a fixed ten cycles. Off-board slots park the read address on the
    // centre cell so the mine board is never addressed outside its extent.
    always_comb begin
        stateD           = stateQ;
        cxD              = cxQ;
        cyD              = cyQ;
        kD               = kQ;
        accD             = accQ;
        boardIf.rdX      = cxQ;
        boardIf.rdY      = cyQ;
        boardIf.wrX      = '0;
        boardIf.wrY      = '0;
        boardIf.countOut = '0;
        boardIf.writeEn  = 1'b0;

        case (stateQ)
            ST_INIT: begin
                cxD  = '0;
                cyD  = '0;
                kD   = K_FIRST;
                accD = '0;
                if (boardIf.start) stateD = ST_SCAN;
            end
            ST_SCAN: begin
                if (nbValid) begin
                    boardIf.rdX = nbX;
                    boardIf.rdY = nbY;
                end
                if (nbValid && boardIf.mineBoardReadValue) accD = accQ + COUNT_W'(1);
                if (kQ == K_LAST) stateD = ST_WRITE;
                else              kD     = kQ + 4'd1;
            end
            ST_WRITE: begin
                boardIf.writeEn  = 1'b1;
                boardIf.wrX      = cxQ;
                boardIf.wrY      = cyQ;
                boardIf.countOut = accQ;
                accD             = '0;
                kD               = K_FIRST;
                if (lastCell) begin
                    stateD = ST_DONE;
                end else begin
                    stateD = ST_SCAN;
                    if (lastCol) begin
                        cxD = '0;
                        cyD = cyQ + YW'(1);
                    end else begin
                        cxD = cxQ + XW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (boardIf.ack) stateD = ST_INIT;
            end
            default: begin
                stateD = ST_INIT;
            end
        endcase
    end

    assign boardIf.init  = (stateQ == ST_INIT);
    assign boardIf.scan  = (stateQ == ST_SCAN);
    assign boardIf.write = (stateQ == ST_WRITE);
    assign boardIf.done  = (stateQ == ST_DONE);

endmodule

// File: tb/tb_count_adjacent_mines.sv
// tb_count_adjacent_mines
// Directed bench for count_adjacent_mines: an 8x8 instance and a 5x3
// instance, each with a small combinational mine board and a recorder
// that captures every count-board write.
module tb_count_adjacent_mines;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int SW = 5;
    localparam int SH = 3;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    int tbCycle     = 0;

    count_adjacent_mines_if #(.BOARD_WIDTH(W),  .BOARD_HEIGHT(H))  bigIf ();
    count_adjacent_mines_if #(.BOARD_WIDTH(SW), .BOARD_HEIGHT(SH)) smallIf ();

    count_adjacent_mines #(.BOARD_WIDTH(W), .BOARD_HEIGHT(H)) uBig (
        .clk     (clk),
        .reset   (reset),
        .boardIf (bigIf)
    );

    count_adjacent_mines #(.BOARD_WIDTH(SW), .BOARD_HEIGHT(SH)) uSmall (
        .clk     (clk),
        .reset   (reset),
        .boardIf (smallIf)
    );

    logic        mineBig   [H][W];
    logic [31:0] expBig    [H][W];
    logic [31:0] gotBig    [H][W];
    int          writesBig;
    int          firstWriteBig;
    int          bigStartCycle;

    logic        mineSmall [SH][SW];
    logic [31:0] expSmall  [SH][SW];
    logic [31:0] gotSmall  [SH][SW];
    int          writesSmall;

    // Free-running clock and a cycle counter advanced on the active edge.
    always #5 clk = ~clk;

    always @(posedge clk) tbCycle <= tbCycle + 1;

    // Mine boards answer combinationally; an off-board read of the small
    // board returns a mine so any stray access corrupts the counts.
    assign bigIf.mineBoardReadValue = mineBig[bigIf.rdY][bigIf.rdX];
    assign smallIf.mineBoardReadValue =
        (smallIf.rdX < 3'd5 && smallIf.rdY < 2'd3) ? mineSmall[smallIf.rdY][smallIf.rdX] : 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Capture 8x8 writes on the falling edge and check row-major order.
    always @(negedge clk) begin
        if (bigIf.writeEn === 1'b1) begin
            if (writesBig == 0) firstWriteBig = tbCycle;
            checkOutput("bigWrOrderX", 32'(bigIf.wrX), 32'(writesBig % W));
            checkOutput("bigWrOrderY", 32'(bigIf.wrY), 32'(writesBig / W));
            gotBig[bigIf.wrY][bigIf.wrX] = 32'(bigIf.countOut);
            writesBig++;
        end
        checkOutput("bigOneHot", 32'($onehot({bigIf.init, bigIf.scan, bigIf.write, bigIf.done})), 32'd1);
    end

    // Capture 5x3 writes and confirm reads never leave the board.
    always @(negedge clk) begin
        if (smallIf.writeEn === 1'b1) begin
            checkOutput("smallWrOrderX", 32'(smallIf.wrX), 32'(writesSmall % SW));
            checkOutput("smallWrOrderY", 32'(smallIf.wrY), 32'(writesSmall / SW));
            if (smallIf.wrX < 3'd5 && smallIf.wrY < 2'd3)
                gotSmall[smallIf.wrY][smallIf.wrX] = 32'(smallIf.countOut);
            writesSmall++;
        end
        if (smallIf.scan === 1'b1)
            checkOutput("smallRdRange", 32'(smallIf.rdX < 3'd5 && smallIf.rdY < 2'd3), 32'd1);
    end

    task automatic clearBig();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                mineBig[y][x] = 1'b0;
                expBig[y][x]  = 32'd0;
            end
    endtask

    task automatic applyStimulus(output int cycles);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) gotBig[y][x] = 32'hFFFF_FFFF;
        writesBig     = 0;
        firstWriteBig = -1;
        @(negedge clk);
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start   = 1'b0;
        bigStartCycle = tbCycle;
        cycles        = 0;
        while (bigIf.done !== 1'b1 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic checkBig(input string tag);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                checkOutput($sformatf("%s(%0d,%0d)", tag, x, y), gotBig[y][x], expBig[y][x]);
    endtask

    task automatic releaseBig(input string tag);
        bigIf.start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput({tag, "DoneHold"}, 32'(bigIf.done), 32'd1);
        checkOutput({tag, "DoneNoWrite"}, 32'(bigIf.writeEn), 32'd0);
        bigIf.start = 1'b0;
        bigIf.ack   = 1'b1;
        @(negedge clk);
        bigIf.ack = 1'b0;
        checkOutput({tag, "AckToInit"}, 32'(bigIf.init), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        bigIf.start   = 1'b0;
        bigIf.ack     = 1'b0;
        smallIf.start = 1'b0;
        smallIf.ack   = 1'b0;
        writesBig     = 0;
        writesSmall   = 0;
        clearBig();
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) begin
                mineSmall[y][x] = 1'b0;
                expSmall[y][x]  = 32'd0;
                gotSmall[y][x]  = 32'hFFFF_FFFF;
            end

        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checkOutput("rstInit",     32'(bigIf.init),     32'd1);
        checkOutput("rstScan",     32'(bigIf.scan),     32'd0);
        checkOutput("rstWriteEn",  32'(bigIf.writeEn),  32'd0);
        checkOutput("rstCountOut", 32'(bigIf.countOut), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset released");

        // Empty board, with the start held during DONE to show it is ignored.
        clearBig();
        applyStimulus(cycles);
        checkOutput("emptyDoneCycles", 32'(cycles), 32'd640);
        checkOutput("emptyWrites", 32'(writesBig), 32'd64);
        checkOutput("emptyFirstWrite", 32'(firstWriteBig - bigStartCycle), 32'd9);
        checkBig("empty");
        releaseBig("empty");

        // Single mine in the top-left corner.
        clearBig();
        mineBig[0][0] = 1'b1;
        expBig[0][1]  = 32'd1;
        expBig[1][0]  = 32'd1;
        expBig[1][1]  = 32'd1;
        applyStimulus(cycles);
        checkOutput("singleDoneCycles", 32'(cycles), 32'd640);
        checkBig("single");
        releaseBig("single");

        // Every cell mined: corners 3, edges 5, interior 8.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                mineBig[y][x] = 1'b1;
                if ((x == 0 || x == W-1) && (y == 0 || y == H-1)) expBig[y][x] = 32'd3;
                else if (x == 0 || x == W-1 || y == 0 || y == H-1) expBig[y][x] = 32'd5;
                else expBig[y][x] = 32'd8;
            end
        applyStimulus(cycles);
        checkOutput("fullWrites", 32'(writesBig), 32'd64);
        checkBig("full");
        releaseBig("full");

        // Two adjacent mines, first interrupted by reset inside cell (2,1).
        clearBig();
        mineBig[4][3] = 1'b1;
        mineBig[4][4] = 1'b1;
        expBig[4][3] = 32'd1;
        expBig[4][4] = 32'd1;
        expBig[3][2] = 32'd1;
        expBig[4][2] = 32'd1;
        expBig[5][2] = 32'd1;
        expBig[3][3] = 32'd2;
        expBig[3][4] = 32'd2;
        expBig[5][3] = 32'd2;
        expBig[5][4] = 32'd2;
        expBig[3][5] = 32'd1;
        expBig[4][5] = 32'd1;
        expBig[5][5] = 32'd1;
        writesBig = 0;
        @(negedge clk);
        bigIf.start = 1'b1;
        @(negedge clk);
        bigIf.start = 1'b0;
        repeat (102) @(negedge clk);
        checkOutput("abortInScan", 32'(bigIf.scan), 32'd1);
        checkOutput("abortWritesBefore", 32'(writesBig), 32'd10);
        reset = 1'b1;
        #1;
        checkOutput("abortWriteEn", 32'(bigIf.writeEn), 32'd0);
        checkOutput("abortInit", 32'(bigIf.init), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abortWritesAfter", 32'(writesBig), 32'd10);
        checkOutput("abortStaysInit", 32'(bigIf.init), 32'd1);
        applyStimulus(cycles);
        checkOutput("pairDoneCycles", 32'(cycles), 32'd640);
        checkBig("pair");
        releaseBig("pair");

        // 5x3 board with a mine in the bottom-right corner.
        mineSmall[2][4] = 1'b1;
        expSmall[1][3]  = 32'd1;
        expSmall[1][4]  = 32'd1;
        expSmall[2][3]  = 32'd1;
        writesSmall = 0;
        @(negedge clk);
        smallIf.start = 1'b1;
        @(negedge clk);
        smallIf.start = 1'b0;
        cycles = 0;
        while (smallIf.done !== 1'b1 && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("smallDoneCycles", 32'(cycles), 32'd150);
        checkOutput("smallWrites", 32'(writesSmall), 32'd15);
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                checkOutput($sformatf("small(%0d,%0d)", x, y), gotSmall[y][x], expSmall[y][x]);
        smallIf.ack = 1'b1;
        @(negedge clk);
        smallIf.ack = 1'b0;
        checkOutput("smallAckToInit", 32'(smallIf.init), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
